// File: rtl/mem_io_resp.sv
// Byte-bus memory/IO responder: 128KB RAM, UART TX FIFO and RX byte, cycle counter, program stop.
// Optional MEM_IO_OOB_TRAP_EN adds illegal-address trapping (oob_err / oob_addr).
module mem_io_resp #(
  parameter int RAM_ADDR_WID = 17,
  parameter int TXQ_LOG      = 4,
  parameter int FULL_MARGIN  = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        prog_stop,
`ifdef MEM_IO_OOB_TRAP_EN
  output logic        oob_err,
  output logic [31:0] oob_addr,
`endif
  output logic        txq_ovf
);

  localparam int DEPTH = 1 << TXQ_LOG;
  localparam logic [TXQ_LOG:0] DEPTH_C  = (TXQ_LOG+1)'(DEPTH);
  localparam logic [TXQ_LOG:0] THRESH_C = (TXQ_LOG+1)'(DEPTH - FULL_MARGIN);

  logic [7:0]              r_ram [2**RAM_ADDR_WID];
  logic [7:0]              r_ramQ;
  logic                    r_selRam;
  logic [7:0]              r_ioQ;
  logic                    r_rxPop;
  logic [31:0]             r_cnt;
  logic [31:0]             r_snap;
  logic                    r_progStop;
  logic                    r_ovf;
  logic                    r_bufFull;
  logic [7:0]              r_txMem [DEPTH];
  logic [TXQ_LOG-1:0]      r_wrPtr;
  logic [TXQ_LOG-1:0]      r_rdPtr;
  logic [TXQ_LOG:0]        r_count;

  logic [17:0]             w_off;
  logic                    w_io;
  logic                    w_illegal;
  logic                    w_rd;
  logic                    w_wr;
  logic                    w_ramWe;
  logic [RAM_ADDR_WID-1:0] w_ramIdx;
  logic [7:0]              w_ioRdData;
  logic                    w_rxPopNext;
  logic                    w_snapLatch;
  logic                    w_stopWr;
  logic                    w_pushReq;
  logic [7:0]              w_pushData;
  logic                    w_txValid;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_push;
  logic                    w_drop;
  logic [TXQ_LOG:0]        w_countNext;

  assign w_off    = mem_a[17:0];
  assign w_io     = (w_off[17:16] == 2'b11);
  assign w_ramIdx = mem_a[RAM_ADDR_WID-1:0];

`ifdef MEM_IO_OOB_TRAP_EN
  assign w_illegal = (|mem_a[31:18]) || (w_off[17:16] == 2'b10);
`else
  logic w_unused;
  assign w_illegal = 1'b0;
  assign w_unused  = ^mem_a[31:18];
`endif

  assign w_rd    = !mem_wr && !w_illegal;
  assign w_wr    = mem_wr && !w_illegal;
  assign w_ramWe = w_wr && !w_io;

  // RAM is read every cycle; the non-blocking write makes a same-address read return the old byte.
  always_ff @(posedge clk_in) begin
    if (w_ramWe) r_ram[w_ramIdx] <= mem_dout;
    r_ramQ <= r_ram[w_ramIdx];
  end

  always_comb begin
    w_ioRdData = 8'h00;
    if (w_rd && w_io) begin
      case (w_off[15:0])
        16'h0000: w_ioRdData = rx_valid ? rx_data : 8'h00;
        16'h0004: w_ioRdData = r_cnt[7:0];
        16'h0005: w_ioRdData = r_snap[15:8];
        16'h0006: w_ioRdData = r_snap[23:16];
        16'h0007: w_ioRdData = r_snap[31:24];
        default:  w_ioRdData = 8'h00;
      endcase
    end
  end

  assign w_rxPopNext = w_rd && w_io && (w_off[15:0] == 16'h0000) && rx_valid;
  assign w_snapLatch = w_rd && w_io && (w_off[15:0] == 16'h0004);
  assign w_stopWr    = w_wr && w_io && (w_off[15:0] == 16'h0004);
  assign w_pushReq   = w_stopWr ||
                       (w_wr && w_io && (w_off[15:0] == 16'h0000) && (mem_dout != 8'h00));
  assign w_pushData  = w_stopWr ? 8'h00 : mem_dout;

  // A push into a full queue still lands when the head leaves in the same cycle.
  assign w_txValid = (r_count != '0);
  assign w_pop     = w_txValid && tx_ready;
  assign w_full    = (r_count == DEPTH_C);
  assign w_push    = w_pushReq && (!w_full || w_pop);
  assign w_drop    = w_pushReq && w_full && !w_pop;

  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + (TXQ_LOG+1)'(1);
      2'b01:   w_countNext = r_count - (TXQ_LOG+1)'(1);
      default: w_countNext = r_count;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_txMem[r_wrPtr] <= w_pushData;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_selRam   <= 1'b0;
      r_ioQ      <= 8'h00;
      r_rxPop    <= 1'b0;
      r_cnt      <= 32'h0;
      r_snap     <= 32'h0;
      r_progStop <= 1'b0;
      r_ovf      <= 1'b0;
      r_bufFull  <= 1'b0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
    end else begin
      r_selRam  <= !w_io && !w_illegal;
      r_ioQ     <= w_ioRdData;
      r_rxPop   <= w_rxPopNext;
      if (w_snapLatch) r_snap <= r_cnt;
      if (!r_progStop) r_cnt <= r_cnt + 32'd1;
      if (w_stopWr) r_progStop <= 1'b1;
      if (w_drop) r_ovf <= 1'b1;
      if (w_push) r_wrPtr <= r_wrPtr + TXQ_LOG'(1);
      if (w_pop) r_rdPtr <= r_rdPtr + TXQ_LOG'(1);
      r_count   <= w_countNext;
      r_bufFull <= (w_countNext >= THRESH_C);
    end
  end

`ifdef MEM_IO_OOB_TRAP_EN
  logic        r_oobErr;
  logic [31:0] r_oobAddr;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_oobErr  <= 1'b0;
      r_oobAddr <= 32'h0;
    end else if (w_illegal && !r_oobErr) begin
      r_oobErr  <= 1'b1;
      r_oobAddr <= mem_a;
    end
  end

  assign oob_err  = r_oobErr;
  assign oob_addr = r_oobAddr;
`endif

  assign mem_din        = r_selRam ? r_ramQ : r_ioQ;
  assign io_buffer_full = r_bufFull;
  assign tx_valid       = w_txValid;
  assign tx_data        = w_txValid ? r_txMem[r_rdPtr] : 8'h00;
  assign rx_pop         = r_rxPop;
  assign prog_stop      = r_progStop;
  assign txq_ovf        = r_ovf;

endmodule

// File: tb/tb_mem_io_resp.sv
// Scoreboard bench for mem_io_resp: stimulus pushes expected read bytes and TX bytes into queues,
// monitors pop and compare whenever mem_din is due or a TX handshake occurs.
module tb_mem_io_resp;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] mem_a = 32'h0;
  logic [7:0]  mem_dout = 8'h0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rx_pop;
  logic        prog_stop;
  logic        txq_ovf;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } rdExp_t;

  rdExp_t      rdQ[$];
  logic [7:0]  txQ[$];
  rdExp_t      curRd;
  logic [7:0]  curTx;
  int          checkCount = 0;
  int          passCount = 0;
  logic        rdPend = 1'b0;
  logic        rdDue = 1'b0;
  int          tbCycle = 0;
  logic [31:0] stopCnt;

  mem_io_resp dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_pop         (rx_pop),
    .prog_stop      (prog_stop),
    .txq_ovf        (txq_ovf)
  );

  always #5 clk_in = ~clk_in;

  // Clocks elapsed since reset release; equals the DUT counter while it runs.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) tbCycle <= 0;
    else tbCycle <= tbCycle + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // A read issued in one cycle is due on mem_din after the following edge.
  always @(posedge clk_in) rdDue <= rdPend;

  always @(negedge clk_in) begin
    if (rdDue) begin
      if (rdQ.size() == 0) begin
        checkOutput("rdUnexpected", 32'h1, 32'h0);
      end else begin
        curRd = rdQ.pop_front();
        checkOutput(curRd.name, {24'h0, mem_din}, {24'h0, curRd.exp});
      end
    end
    if (rst_in && tx_valid && tx_ready) begin
      if (txQ.size() == 0) begin
        checkOutput("txUnexpected", {24'h0, tx_data}, 32'h100);
      end else begin
        curTx = txQ.pop_front();
        checkOutput("txByte", {24'h0, tx_data}, {24'h0, curTx});
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] data, input logic wr,
                               input logic chk, input logic [7:0] exp, input string name);
    rdExp_t e;
    mem_a    = addr;
    mem_dout = data;
    mem_wr   = wr;
    if (chk) begin
      e.exp  = exp;
      e.name = name;
      rdQ.push_back(e);
      rdPend = 1'b1;
    end
    tick();
    rdPend   = 1'b0;
    mem_a    = 32'h0;
    mem_dout = 8'h0;
    mem_wr   = 1'b0;
  endtask

  task automatic writeByte(input logic [31:0] addr, input logic [7:0] data);
    applyStimulus(addr, data, 1'b1, 1'b0, 8'h0, "");
  endtask

  task automatic readExpect(input logic [31:0] addr, input logic [7:0] exp, input string name);
    applyStimulus(addr, 8'h0, 1'b0, 1'b1, exp, name);
  endtask

  task automatic waitTxDrain(input int bound, input string name);
    for (int i = 0; i < bound && tx_valid; i++) tick();
    checkOutput(name, {31'h0, tx_valid}, 32'h0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_memDin"}, {24'h0, mem_din}, 32'h0);
    checkOutput({tag, "_bufFull"}, {31'h0, io_buffer_full}, 32'h0);
    checkOutput({tag, "_txValid"}, {31'h0, tx_valid}, 32'h0);
    checkOutput({tag, "_txData"}, {24'h0, tx_data}, 32'h0);
    checkOutput({tag, "_rxPop"}, {31'h0, rx_pop}, 32'h0);
    checkOutput({tag, "_progStop"}, {31'h0, prog_stop}, 32'h0);
    checkOutput({tag, "_txqOvf"}, {31'h0, txq_ovf}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tick();
    tick();
    checkResetOutputs("reset");
    rst_in = 1'b1;

    writeByte(32'h0000_0123, 8'hA5);
    readExpect(32'h0000_0123, 8'hA5, "ramRead");
    writeByte(32'h0000_0040, 8'h22);
    applyStimulus(32'h0000_0040, 8'h11, 1'b1, 1'b1, 8'h22, "readBeforeWrite");
    readExpect(32'h0000_0040, 8'h11, "readAfterWrite");
    writeByte(32'h0001_FFFF, 8'h5A);
    readExpect(32'h0001_FFFF, 8'h5A, "ramTop");
    readExpect(32'h0002_0123, 8'hA5, "aliasRam");
    readExpect(32'hFFFC_0123, 8'hA5, "highBitsIgnored");
    readExpect(32'h0003_0008, 8'h00, "ioOther");

    // Counter equals 1000 in the issue cycle, so the snapshot bytes are E8 03 00 00.
    while (tbCycle < 1000) tick();
    readExpect(32'h0003_0004, 8'hE8, "cntByte0");
    readExpect(32'h0003_0005, 8'h03, "snapByte1");
    readExpect(32'h0003_0006, 8'h00, "snapByte2");
    readExpect(32'h0003_0007, 8'h00, "snapByte3");

    tx_ready = 1'b0;
    writeByte(32'h0003_0000, 8'h48);
    txQ.push_back(8'h48);
    writeByte(32'h0003_0000, 8'h69);
    txQ.push_back(8'h69);
    writeByte(32'h0003_0000, 8'h00);
    checkOutput("txValidHi", {31'h0, tx_valid}, 32'h1);
    checkOutput("txHeadHi", {24'h0, tx_data}, 32'h48);
    checkOutput("bufFullHi", {31'h0, io_buffer_full}, 32'h0);
    tx_ready = 1'b1;
    waitTxDrain(10, "txDrainHi");
    tx_ready = 1'b0;
    checkOutput("txQueueConsumedHi", txQ.size(), 32'h0);

    for (int i = 1; i <= 17; i++) begin
      writeByte(32'h0003_0000, i[7:0]);
      if (i <= 16) txQ.push_back(i[7:0]);
      if (i == 11) checkOutput("bufFullAt11", {31'h0, io_buffer_full}, 32'h0);
      if (i == 12) checkOutput("bufFullAt12", {31'h0, io_buffer_full}, 32'h1);
      if (i == 16) checkOutput("ovfAt16", {31'h0, txq_ovf}, 32'h0);
    end
    checkOutput("ovfAt17", {31'h0, txq_ovf}, 32'h1);
    checkOutput("txHeadFull", {24'h0, tx_data}, 32'h01);
    tx_ready = 1'b1;
    waitTxDrain(40, "txDrainFull");
    tx_ready = 1'b0;
    checkOutput("txQueueConsumedFull", txQ.size(), 32'h0);
    checkOutput("bufFullDrained", {31'h0, io_buffer_full}, 32'h0);
    checkOutput("ovfSticky", {31'h0, txq_ovf}, 32'h1);

    rx_data  = 8'h37;
    rx_valid = 1'b1;
    readExpect(32'h0003_0000, 8'h37, "rxRead");
    checkOutput("rxPopHigh", {31'h0, rx_pop}, 32'h1);
    rx_valid = 1'b0;
    tick();
    checkOutput("rxPopLow", {31'h0, rx_pop}, 32'h0);
    readExpect(32'h0003_0000, 8'h00, "rxEmptyRead");
    checkOutput("rxPopIdle", {31'h0, rx_pop}, 32'h0);

    // The stop write's own edge still increments the counter, then it holds.
    stopCnt = 32'(tbCycle) + 32'd1;
    writeByte(32'h0003_0004, 8'h55);
    txQ.push_back(8'h00);
    checkOutput("progStop", {31'h0, prog_stop}, 32'h1);
    checkOutput("txValidStop", {31'h0, tx_valid}, 32'h1);
    checkOutput("txHeadStop", {24'h0, tx_data}, 32'h00);
    repeat (3) tick();
    readExpect(32'h0003_0004, stopCnt[7:0], "cntFrozen");
    repeat (5) tick();
    readExpect(32'h0003_0005, stopCnt[15:8], "snapFrozen");
    readExpect(32'h0003_0004, stopCnt[7:0], "cntFrozenAgain");

    writeByte(32'h0003_0000, 8'h41);
    txQ.push_back(8'h41);
    writeByte(32'h0003_0000, 8'h42);
    txQ.push_back(8'h42);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    checkOutput("txHeadMidDrain", {24'h0, tx_data}, 32'h41);
    #2;
    rst_in = 1'b0;
    #1;
    txQ.delete();
    checkResetOutputs("midReset");
    tick();
    rst_in = 1'b1;
    tick();
    checkOutput("rdQueueDrained", rdQ.size(), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
